// File: rtl/edge_pkg.sv
// Shared types and limits for the multi-channel edge detector.
package edge_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  localparam int NUM_CH_MIN       = 1;
  localparam int NUM_CH_MAX       = 32;
  localparam int SYNC_STAGES_MIN  = 0;
  localparam int SYNC_STAGES_MAX  = 3;
  localparam int DEBOUNCE_LEN_MIN = 1;
  localparam int DEBOUNCE_LEN_MAX = 256;

  // True when a detect pulse matches the channel's selected event mode.
  function automatic logic mode_hit(edge_mode_e mode, logic re, logic fe);
    return (re && (mode == EDGE_RISE || mode == EDGE_BOTH)) ||
           (fe && (mode == EDGE_FALL || mode == EDGE_BOTH));
  endfunction

endpackage

// File: rtl/edge_chan.sv
// One channel: input synchronizer, debounce filter and registered edge pulses.
module edge_chan #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic a_i,
  output logic level_o,
  output logic re_o,
  output logic fe_o
);

  localparam int            CW       = $clog2(DEBOUNCE_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_LEN - 1);

  logic          sync_out;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          re_q, fe_q;

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign sync_out = a_i;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      // Shift the raw input through the synchronizer chain.
      always_ff @(posedge clk) begin
        if (reset) sync_q <= '0;
        else       sync_q <= (sync_q << 1) | SYNC_STAGES'(a_i);
      end
      assign sync_out = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Count cycles of disagreement; accept the new level on the last one.
  // The counter stops at DEBOUNCE_LEN-1, so it can never wrap.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_out != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_out;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Filter state plus edge pulses registered alongside the level change.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      re_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      re_q    <= level_d & ~level_q;
      fe_q    <= ~level_d & level_q;
    end
  end

  assign level_o = level_q;
  assign re_o    = re_q;
  assign fe_o    = fe_q;

endmodule

// File: rtl/edge_detect_mc.sv
// Multi-channel debounced edge detector with sticky pending flags and irq.
module edge_detect_mc
  import edge_pkg::*;
#(
  parameter int NUM_CH       = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_LEN = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     a_in,
  input  logic [2*NUM_CH-1:0]   mode_i,
  input  logic [NUM_CH-1:0]     clr_i,
  input  logic [NUM_CH-1:0]     irq_en_i,
  output logic [NUM_CH-1:0]     level_o,
  output logic [NUM_CH-1:0]     RE_detected,
  output logic [NUM_CH-1:0]     FE_detected,
  output logic [NUM_CH-1:0]     pending_o,
  output logic                  irq_o
);

  if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX ||
      SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX ||
      DEBOUNCE_LEN < DEBOUNCE_LEN_MIN || DEBOUNCE_LEN > DEBOUNCE_LEN_MAX) begin : g_bad_param
    $error("edge_detect_mc: parameter out of range");
  end

  logic [NUM_CH-1:0] pending_q, pending_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    edge_chan #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DEBOUNCE_LEN (DEBOUNCE_LEN)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .a_i     (a_in[g]),
      .level_o (level_o[g]),
      .re_o    (RE_detected[g]),
      .fe_o    (FE_detected[g])
    );
  end

  // Sticky flags: a qualifying pulse sets, clear strobe clears, set wins.
  always_comb begin
    pending_d = pending_q;
    for (int n = 0; n < NUM_CH; n++) begin
      pending_d[n] = mode_hit(edge_mode_e'(mode_i[2*n +: 2]), RE_detected[n], FE_detected[n])
                     | (pending_q[n] & ~clr_i[n]);
    end
  end

  // Pending flag register.
  always_ff @(posedge clk) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  assign pending_o = pending_q;
  assign irq_o     = |(pending_q & irq_en_i);

endmodule

// File: tb/tb_edge_detect_mc.sv
module tb_edge_detect_mc;
  localparam int MAXT = 2048;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  a_in = '0;
  logic [15:0] mode_i = '0;
  logic [7:0]  clr_i = '0;
  logic [7:0]  irq_en_i = '0;
  logic [7:0]  level_o, RE_detected, FE_detected, pending_o;
  logic        irq_o;
  logic [1:0]  level1, re1, fe1, pend1;
  logic        irq1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  edge_detect_mc dut0 (
    .clk(clk), .reset(reset), .a_in(a_in), .mode_i(mode_i), .clr_i(clr_i),
    .irq_en_i(irq_en_i), .level_o(level_o), .RE_detected(RE_detected),
    .FE_detected(FE_detected), .pending_o(pending_o), .irq_o(irq_o));

  edge_detect_mc #(.NUM_CH(2), .SYNC_STAGES(0), .DEBOUNCE_LEN(1)) dut1 (
    .clk(clk), .reset(reset), .a_in(a_in[1:0]), .mode_i(4'b1111), .clr_i(2'b00),
    .irq_en_i(2'b11), .level_o(level1), .RE_detected(re1),
    .FE_detected(fe1), .pending_o(pend1), .irq_o(irq1));

  // ---------------- behavioural model (window based) ----------------
  int         t = -1;
  logic [7:0] a_h   [MAXT];
  logic       rst_h [MAXT];
  logic [7:0] lv_h  [2][MAXT];
  logic [7:0] re_h  [2][MAXT];
  logic [7:0] fe_h  [2][MAXT];
  logic [7:0] pd_h  [2][MAXT];

  function automatic int sync_of(int d); return (d == 0) ? 2 : 0; endfunction
  function automatic int len_of(int d);  return (d == 0) ? 4 : 1; endfunction

  // Synchronized value seen at edge j: the input S edges earlier, unless a reset intervened.
  function automatic logic s_of(int d, int ch, int j);
    int s = sync_of(d);
    if (j - s < 0) return 1'b0;
    for (int i = j - s; i < j; i++) if (rst_h[i]) return 1'b0;
    return a_h[j - s][ch];
  endfunction

  // Level after edge t: flips only when the last L edges all disagreed with a stable level.
  function automatic logic lv_of(int d, int ch, int tt);
    int   l = len_of(d);
    logic prev;
    prev = (tt == 0) ? 1'b0 : lv_h[d][tt-1][ch];
    if (rst_h[tt]) return 1'b0;
    if (tt - l + 1 < 0) return prev;
    for (int j = tt - l + 1; j <= tt; j++)
      if (rst_h[j] || s_of(d, ch, j) == prev) return prev;
    for (int j = tt - l + 1; j < tt; j++)
      if (lv_h[d][j][ch] != prev) return prev;
    return ~prev;
  endfunction

  always @(posedge clk) begin
    if (t < MAXT - 1) t = t + 1;
    a_h[t]   = a_in;
    rst_h[t] = reset;
    for (int d = 0; d < 2; d++) begin
      for (int ch = 0; ch < 8; ch++) begin
        logic prv, md_r, md_f, clr, set, pprev;
        lv_h[d][t][ch] = lv_of(d, ch, t);
        prv = (t == 0) ? 1'b0 : lv_h[d][t-1][ch];
        re_h[d][t][ch] = !reset && lv_h[d][t][ch] && !prv;
        fe_h[d][t][ch] = !reset && !lv_h[d][t][ch] && prv;
        md_r  = (d == 0) ? mode_i[2*ch]   : 1'b1;
        md_f  = (d == 0) ? mode_i[2*ch+1] : 1'b1;
        clr   = (d == 0) ? clr_i[ch] : 1'b0;
        set   = (t > 0) && ((md_r && re_h[d][t-1][ch]) || (md_f && fe_h[d][t-1][ch]));
        pprev = (t == 0) ? 1'b0 : pd_h[d][t-1][ch];
        pd_h[d][t][ch] = reset ? 1'b0 : set ? 1'b1 : clr ? 1'b0 : pprev;
      end
    end
  end

  task automatic chkv(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  // ---------------- per-cycle compare against the model ----------------
  always @(posedge clk) begin
    #1;
    if (t >= 0) begin
      chkv("level0", level_o,     lv_h[0][t]);
      chkv("re0",    RE_detected, re_h[0][t]);
      chkv("fe0",    FE_detected, fe_h[0][t]);
      chkv("pend0",  pending_o,   pd_h[0][t]);
      chkv("irq0",   {7'd0, irq_o}, {7'd0, |(pd_h[0][t] & irq_en_i)});
      chkv("level1", {6'd0, level1}, lv_h[1][t] & 8'h03);
      chkv("re1",    {6'd0, re1},    re_h[1][t] & 8'h03);
      chkv("fe1",    {6'd0, fe1},    fe_h[1][t] & 8'h03);
      chkv("pend1",  {6'd0, pend1},  pd_h[1][t] & 8'h03);
      chkv("irq1",   {7'd0, irq1},   {7'd0, |(pd_h[1][t] & 8'h03)});
    end
  end

  // Pulse counters on the default-parameter instance.
  int re_cnt [8];
  int fe_cnt [8];
  initial for (int i = 0; i < 8; i++) begin re_cnt[i] = 0; fe_cnt[i] = 0; end
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 8; i++) begin
      if (RE_detected[i] === 1'b1) re_cnt[i]++;
      if (FE_detected[i] === 1'b1) fe_cnt[i]++;
    end
  end

  task automatic wn(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    chkv(name, {7'd0, got}, {7'd0, exp});
  endtask

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    int b_re, b_fe;
    wn(4);
    chkv("rst_level", level_o, 8'h00);
    chkv("rst_pend",  pending_o, 8'h00);
    chk1("rst_irq",   irq_o, 1'b0);

    reset = 1'b0;
    mode_i = 16'h03ED;
    irq_en_i = 8'h01;
    wn(3);

    // ch0 rising, mode 01; dut1 is the zero-sync, no-filter instance
    a_in[0] = 1'b1;
    wn(1);
    chk1("s0l1_re_k", re1[0], 1'b1);
    chk1("def_re_k",  RE_detected[0], 1'b0);
    wn(1);
    chk1("s0l1_re_k1", re1[0], 1'b0);
    wn(3);
    chk1("re0_k4",    RE_detected[0], 1'b0);
    chk1("lvl0_k4",   level_o[0], 1'b0);
    wn(1);
    chk1("re0_k5",    RE_detected[0], 1'b1);
    chk1("lvl0_k5",   level_o[0], 1'b1);
    chk1("pend0_k5",  pending_o[0], 1'b0);
    wn(1);
    chk1("re0_k6",    RE_detected[0], 1'b0);
    chk1("pend0_k6",  pending_o[0], 1'b1);
    chk1("irq_k6",    irq_o, 1'b1);

    // ch1 glitch of 3 sampled cycles, then a 4-cycle pulse
    b_re = re_cnt[1]; b_fe = fe_cnt[1];
    a_in[1] = 1'b1; wn(3); a_in[1] = 1'b0; wn(12);
    chk1("glitch_lvl", level_o[1], 1'b0);
    chkv("glitch_re", 8'(re_cnt[1] - b_re), 8'd0);
    chkv("glitch_fe", 8'(fe_cnt[1] - b_fe), 8'd0);
    a_in[1] = 1'b1; wn(4); a_in[1] = 1'b0; wn(12);
    chkv("pulse4_re", 8'(re_cnt[1] - b_re), 8'd1);
    chkv("pulse4_fe", 8'(fe_cnt[1] - b_fe), 8'd1);

    // ch2 falling-only mode
    b_re = re_cnt[2]; b_fe = fe_cnt[2];
    a_in[2] = 1'b1; wn(12);
    chk1("fall_mode_rise_pend", pending_o[2], 1'b0);
    chkv("fall_mode_re", 8'(re_cnt[2] - b_re), 8'd1);
    a_in[2] = 1'b0; wn(12);
    chk1("fall_mode_fall_pend", pending_o[2], 1'b1);
    chkv("fall_mode_fe", 8'(fe_cnt[2] - b_fe), 8'd1);

    // ch3 clear colliding with a new event, then a lone clear
    a_in[3] = 1'b1; wn(12);
    chk1("ch3_pend_rise", pending_o[3], 1'b1);
    a_in[3] = 1'b0; wn(6);
    chk1("ch3_fe_pulse", FE_detected[3], 1'b1);
    clr_i = 8'h08; wn(1); clr_i = 8'h00;
    chk1("ch3_set_wins", pending_o[3], 1'b1);
    irq_en_i = 8'h09; mode_i = 16'h0000; wn(2);
    chkv("mode_chg_pend", pending_o & 8'h0F, 8'h0F);
    chk1("irq_en_chg", irq_o, 1'b1);
    clr_i = 8'h0F; wn(1); clr_i = 8'h00; wn(1);
    chk1("ch3_clr", pending_o[3], 1'b0);
    chk1("irq_clr", irq_o, 1'b0);
    mode_i = 16'h03ED;

    // ch4 reset two cycles into the debounce count
    a_in[4] = 1'b1; wn(4);
    b_re = re_cnt[4];
    reset = 1'b1; wn(2);
    chk1("rst_mid_re4",  RE_detected[4], 1'b0);
    chk1("rst_mid_lvl4", level_o[4], 1'b0);
    chkv("rst_mid_pend", pending_o, 8'h00);
    reset = 1'b0;
    wn(5);
    chk1("rel_re4_m4", RE_detected[4], 1'b0);
    wn(1);
    chk1("rel_re4_m5", RE_detected[4], 1'b1);
    wn(10);
    chkv("rel_re4_cnt", 8'(re_cnt[4] - b_re), 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/edge_detect_mc.md
EDGE_DETECT_MC -- requirements
Module: edge_detect_mc

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 8, meaning the number of independent input channels (legal range 1..32).
REQ-002 The module SHALL have parameter SYNC_STAGES, default 2, meaning the flip-flop synchronizer depth per channel (legal range 0..3; 0 = bypass, input already synchronous).
REQ-003 The module SHALL have parameter DEBOUNCE_LEN, default 4, meaning the number of consecutive cycles a new level must persist before acceptance (legal range 1..256; 1 = no filtering).
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 Ports SHALL be:
  clk  input  1  sole clock, rising edge
  reset  input  1  synchronous active-high reset
  a_in  input  NUM_CH  raw channel inputs, may be asynchronous
  mode_i  input  2*NUM_CH  per-channel event mode, channel n at bits [2n+1:2n]
  clr_i  input  NUM_CH  write-1-to-clear for pending_o, one-cycle strobe
  irq_en_i  input  NUM_CH  per-channel interrupt enable
  level_o  output  NUM_CH  filtered (synchronized, debounced) level
  RE_detected  output  NUM_CH  one-cycle rising-edge pulse per channel
  FE_detected  output  NUM_CH  one-cycle falling-edge pulse per channel
  pending_o  output  NUM_CH  sticky event flags
  irq_o  output  1  interrupt request

Function
REQ-006 Each channel SHALL pass a_in[n] through SYNC_STAGES flip-flops; with SYNC_STAGES=0 the synchronizer output SHALL equal a_in[n].
REQ-007 Each channel SHALL keep a debounce counter that increments each cycle the synchronizer output differs from level_o[n] and clears to 0 each cycle it equals level_o[n].
REQ-008 level_o[n] SHALL take the synchronizer value on the clock edge at which that value has differed for DEBOUNCE_LEN consecutive sampled cycles; the counter SHALL clear on that same edge.
REQ-009 The counter SHALL be $clog2(DEBOUNCE_LEN+1) bits wide and SHALL never wrap.
REQ-010 Latency: if a_in[n] is first sampled at its new level on edge k and held, level_o[n] SHALL change after edge k+SYNC_STAGES+DEBOUNCE_LEN-1.
REQ-011 RE_detected[n] SHALL be high for exactly the one cycle after level_o[n] goes 0->1; FE_detected[n] likewise for 1->0. Both outputs are registered, independent of mode_i, and never high together.
REQ-012 A pulse on a_in[n] shorter than DEBOUNCE_LEN sampled cycles SHALL produce no change on level_o[n], RE_detected or FE_detected.
REQ-013 mode_i encoding: 00 = off, 01 = rising, 10 = falling, 11 = both; a qualifying event is a detect pulse matching the channel's mode.
REQ-014 pending_o[n] SHALL set on the clock edge after a qualifying event is asserted, i.e. one cycle after the corresponding detect pulse rises.
REQ-015 clr_i[n]=1 SHALL clear pending_o[n] on the next edge; simultaneous set and clear on the same channel SHALL leave pending_o[n]=1 (set wins).
REQ-016 Changing mode_i or irq_en_i SHALL NOT alter existing pending_o bits.
REQ-017 irq_o SHALL be the combinational OR of (pending_o & irq_en_i), derived only from registers and inputs.

Reset
REQ-018 While reset=1, synchronizer flops, debounce counters, level_o, RE_detected, FE_detected and pending_o SHALL all go to 0 on the clock edge; irq_o SHALL therefore read 0.
REQ-019 Reset asserted mid-debounce SHALL discard the partial count; no pulse SHALL result from the aborted transition.
REQ-020 A channel held high through reset release SHALL produce exactly one RE_detected pulse after the REQ-010 latency, counted from the first post-reset sampling edge.

Structure
REQ-021 A shared package edge_pkg SHALL hold the 2-bit mode enum (EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH) and the parameter range limits.
REQ-022 The per-channel synchronizer, debounce and detect logic SHALL be a sub-module edge_chan, instantiated NUM_CH times by a generate loop; the pending register and irq logic SHALL sit at top level.

Verification
REQ-023 Defaults, mode 01 on ch0: a_in[0] 0->1 held, first sampled at edge k -> RE_detected[0] high exactly one cycle after edge k+5; pending_o[0]=1 after edge k+6; irq_o=1 when irq_en_i[0]=1.
REQ-024 Glitch: a_in[1] high for 3 cycles, DEBOUNCE_LEN=4 -> level_o[1], RE_detected[1] and FE_detected[1] stay 0; a 4-cycle pulse -> one RE_detected pulse then one FE_detected pulse.
REQ-025 Mode 10 on ch2, rising then falling transition -> only the falling transition sets pending_o[2]; both RE_detected[2] and FE_detected[2] pulse.
REQ-026 clr_i[3] strobed in the same cycle a new qualifying ch3 event arrives -> pending_o[3] stays 1; a later clr_i[3] alone -> pending_o[3]=0, irq_o=0.
REQ-027 SYNC_STAGES=0, DEBOUNCE_LEN=1 -> RE_detected pulses one cycle after the edge where a_in is sampled high, matching a single-register edge detector.
REQ-028 Reset asserted two cycles into a debounce count with a_in[4] held high -> no pulse during reset; exactly one RE_detected[4] pulse at the REQ-010 latency after release.
